// File: rtl/ysyx_040066_dmem_resp.sv
// ----------------------------------------------------------------------------
// ysyx_040066_dmem_resp
// Memory-side responder for the core data port. Services MemRd/MemWr requests
// from a 64-bit-wide internal SRAM and replies after a fixed latency.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   MemRd, MemWr          request strobes, held by the core until data_valid
//   addr, wr_len          byte address and access size (0=1B .. 3=8B)
//   wr_mask, data_Wr      lane byte enables and lane-aligned write data
//   data_Rd               full aligned word for reads (0 for writes/errors)
//   data_valid            one-cycle completion pulse
//   data_error            qualifies data_valid; access fault
//   busy                  FSM not idle
//   init_wen/idx/data     back-door word write, honoured in any state
// ----------------------------------------------------------------------------
module ysyx_040066_dmem_resp #(
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           MemRd,
    input  logic                           MemWr,
    input  logic [63:0]                    addr,
    input  logic [2:0]                     wr_len,
    input  logic [7:0]                     wr_mask,
    input  logic [63:0]                    data_Wr,
    output logic [63:0]                    data_Rd,
    output logic                           data_valid,
    output logic                           data_error,
    output logic                           busy,
    input  logic                           init_wen,
    input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx,
    input  logic [63:0]                    init_data
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [63:0] ADDR_LIMIT = ADDR_BASE + 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
    localparam bit          LAT_ONE    = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    logic [63:0] mem [DEPTH_WORDS];

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic [7:0]         mask_q;
    logic [63:0]        wdata_q;
    logic               err_q;
    logic [63:0]        rdata_q;
    logic               valid_q;
    logic               error_q;
    logic               busy_q;

    logic               req_c;
    logic               misalign_c;
    logic               err_c;
    logic [IDX_W-1:0]   idx_c;
    logic               commit_c;
    logic [63:0]        bmask_c;
    logic [63:0]        base_word_c;
    logic [63:0]        merged_c;

    assign req_c = MemRd | MemWr;
    assign idx_c = IDX_W'((addr - ADDR_BASE) >> 3);

    // Natural alignment check for the requested access size
    always_comb begin
        misalign_c = 1'b0;
        case (wr_len)
            3'd0:    misalign_c = 1'b0;
            3'd1:    misalign_c = addr[0];
            3'd2:    misalign_c = |addr[1:0];
            default: misalign_c = |addr[2:0];
        endcase
    end

    // Access fault: conflicting strobes, illegal size, misaligned, out of window
    assign err_c = (MemRd & MemWr)
                 | (wr_len > 3'd3)
                 | misalign_c
                 | (addr < ADDR_BASE)
                 | (addr >= ADDR_LIMIT);

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            mask_q  <= 8'd0;
            wdata_q <= 64'd0;
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    error_q <= 1'b0;
                    rdata_q <= 64'd0;
                    if (req_c) begin
                        idx_q   <= idx_c;
                        wr_q    <= MemWr;
                        mask_q  <= wr_mask;
                        wdata_q <= data_Wr;
                        err_q   <= err_c;
                        busy_q  <= 1'b1;
                        if (LAT_ONE) begin
                            // Single-cycle latency: sample the array on acceptance
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            error_q <= err_c;
                            rdata_q <= (err_c || MemWr) ? 64'd0 : mem[idx_c];
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_c) begin
                        // Core withdrew the request: abort with nothing committed
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= 4'd0;
                        valid_q <= 1'b1;
                        error_q <= err_q;
                        rdata_q <= (err_q || wr_q) ? 64'd0 : mem[idx_q];
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    error_q <= 1'b0;
                    rdata_q <= 64'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    error_q <= 1'b0;
                    rdata_q <= 64'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write commits at the edge ending RESP; a reset at that edge suppresses it
    assign commit_c = (state_q == S_RESP) & wr_q & ~err_q & ~rst;

    always_comb begin
        bmask_c = 64'd0;
        for (int b = 0; b < 8; b++) begin
            bmask_c[8*b +: 8] = {8{mask_q[b]}};
        end
    end

    // On a same-word back-door collision, init_data fills the unmasked bytes
    assign base_word_c = (init_wen && (init_idx == idx_q)) ? init_data : mem[idx_q];
    assign merged_c    = (base_word_c & ~bmask_c) | (wdata_q & bmask_c);

    // Array storage; not cleared by reset
    always_ff @(posedge clk) begin
        if (init_wen) begin
            mem[init_idx] <= init_data;
        end
        if (commit_c) begin
            mem[idx_q] <= merged_c;
        end
    end

    assign data_Rd    = rdata_q;
    assign data_valid = valid_q;
    assign data_error = error_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ysyx_040066_dmem_resp.sv
// ----------------------------------------------------------------------------
// tb_ysyx_040066_dmem_resp
// Scoreboard bench: three responders (LATENCY 2, 4, 1) share the data/back-door
// inputs, each has its own request strobes. Expected responses (instance,
// cycle, data, error) are queued at issue time and checked by a monitor.
// ----------------------------------------------------------------------------
module tb_ysyx_040066_dmem_resp;

    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct {
        int          inst;
        int          cyc;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_r [3];
    logic        wr_r [3];
    logic [63:0] addr;
    logic [2:0]  wr_len;
    logic [7:0]  wr_mask;
    logic [63:0] data_Wr;
    logic        init_wen;
    logic [11:0] init_idx;
    logic [63:0] init_data;
    logic [63:0] drd [3];
    logic        dv  [3];
    logic        de  [3];
    logic        bz  [3];

    exp_t sbq [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_040066_dmem_resp #(.LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .MemRd(rd_r[0]), .MemWr(wr_r[0]), .addr(addr),
        .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr), .data_Rd(drd[0]),
        .data_valid(dv[0]), .data_error(de[0]), .busy(bz[0]),
        .init_wen(init_wen), .init_idx(init_idx), .init_data(init_data)
    );

    ysyx_040066_dmem_resp #(.LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .MemRd(rd_r[1]), .MemWr(wr_r[1]), .addr(addr),
        .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr), .data_Rd(drd[1]),
        .data_valid(dv[1]), .data_error(de[1]), .busy(bz[1]),
        .init_wen(init_wen), .init_idx(init_idx), .init_data(init_data)
    );

    ysyx_040066_dmem_resp #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .MemRd(rd_r[2]), .MemWr(wr_r[2]), .addr(addr),
        .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr), .data_Rd(drd[2]),
        .data_valid(dv[2]), .data_error(de[2]), .busy(bz[2]),
        .init_wen(init_wen), .init_idx(init_idx), .init_data(init_data)
    );

    function automatic int lat_of(int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] pre(int i);
        return {32'hC0DE_0000 + 32'(i), 32'hF00D_0000 + 32'(i)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every data_valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv[k] === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid inst %0d @cycle %0d", k, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_inst",  64'(k),     64'(e.inst));
                    chk("resp_cycle", 64'(cyc),   64'(e.cyc));
                    chk("resp_data",  drd[k],     e.data);
                    chk("resp_err",   64'(de[k]), 64'(e.err));
                end
            end
        end
    end

    // Issue one request on instance k and hold it until data_valid
    task automatic issue(int k, bit rd, bit wr, logic [63:0] a, logic [2:0] len,
                         logic [7:0] m, logic [63:0] wd, logic [63:0] ed, bit ee,
                         bit keep);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        chk("busy_idle", 64'(bz[k]), 64'd0);
        addr    = a;
        wr_len  = len;
        wr_mask = m;
        data_Wr = wd;
        rd_r[k] = rd;
        wr_r[k] = wr;
        e.inst  = k;
        e.cyc   = cyc + lat_of(k);
        e.data  = ed;
        e.err   = ee;
        sbq.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            chk("busy_active", 64'(bz[k]), 64'd1);
            if (dv[k] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for data_valid inst %0d addr %h", k, a);
        end
        if (!keep) begin
            rd_r[k] = 1'b0;
            wr_r[k] = 1'b0;
        end
    endtask

    task automatic init_word(int idx, logic [63:0] d);
        @(posedge clk); #1;
        init_wen  = 1'b1;
        init_idx  = 12'(idx);
        init_data = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e0;
        rst       = 1'b1;
        addr      = 64'd0;
        wr_len    = 3'd0;
        wr_mask   = 8'd0;
        data_Wr   = 64'd0;
        init_wen  = 1'b0;
        init_idx  = 12'd0;
        init_data = 64'd0;
        for (int k = 0; k < 3; k++) begin
            rd_r[k] = 1'b0;
            wr_r[k] = 1'b0;
        end

        // Preload through the back door while in reset
        init_word(0, 64'h1122_3344_5566_7788);
        init_word(1, 64'h0);
        for (int i = 2; i < 18; i++) init_word(i, pre(i));
        init_word(4095, 64'hDEAD_BEEF_CAFE_F00D);
        @(posedge clk); #1;
        init_wen = 1'b0;

        chk("rst_valid", 64'(dv[0]), 64'd0);
        chk("rst_error", 64'(de[0]), 64'd0);
        chk("rst_rdata", drd[0],     64'd0);
        chk("rst_busy",  64'(bz[0]), 64'd0);
        rst = 1'b0;

        // LATENCY 2: basic read, partial store, back-to-back stores
        issue(0, 1, 0, BASE,      3'd3, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 0, 0);
        issue(0, 0, 1, BASE + 4,  3'd2, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'd0, 0, 0);
        issue(0, 1, 0, BASE,      3'd3, 8'h00, 64'd0, 64'hAABB_CCDD_5566_7788, 0, 0);
        issue(0, 0, 1, BASE + 8,  3'd3, 8'h01, 64'h0000_0000_0000_00FF, 64'd0, 0, 1);
        issue(0, 0, 1, BASE + 8,  3'd3, 8'h02, 64'h0000_0000_0000_EE00, 64'd0, 0, 0);
        issue(0, 1, 0, BASE + 8,  3'd3, 8'h00, 64'd0, 64'h0000_0000_0000_EEFF, 0, 0);

        // Faults: below window, above window, misaligned store, both strobes, bad size
        issue(0, 1, 0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, 64'd0, 1, 0);
        issue(0, 1, 0, 64'h8000_8000, 3'd3, 8'h00, 64'd0, 64'd0, 1, 0);
        issue(0, 0, 1, BASE + 2,  3'd2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
        issue(0, 1, 0, BASE,      3'd3, 8'h00, 64'd0, 64'hAABB_CCDD_5566_7788, 0, 0);
        issue(0, 1, 1, BASE + 8,  3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
        issue(0, 1, 0, BASE + 8,  3'd3, 8'h00, 64'd0, 64'h0000_0000_0000_EEFF, 0, 0);
        issue(0, 1, 0, BASE,      3'd5, 8'h00, 64'd0, 64'd0, 1, 0);
        // Last word in the window and a narrow aligned read
        issue(0, 1, 0, 64'h8000_7FF8, 3'd3, 8'h00, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
        issue(0, 1, 0, BASE + 6,  3'd1, 8'h00, 64'd0, 64'hAABB_CCDD_5566_7788, 0, 0);

        // LATENCY 4: store withdrawn mid-WAIT
        @(posedge clk); #1;
        addr = BASE; wr_len = 3'd3; wr_mask = 8'hFF; data_Wr = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_r[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_busy_wait", 64'(bz[1]), 64'd1);
        wr_r[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_busy_idle", 64'(bz[1]), 64'd0);
        issue(1, 1, 0, BASE, 3'd3, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 0, 0);

        // LATENCY 4: reset asserted mid-WAIT
        @(posedge clk); #1;
        addr = BASE; wr_len = 3'd3; wr_mask = 8'hFF; data_Wr = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_r[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("wait_rst_valid", 64'(dv[1]), 64'd0);
        chk("wait_rst_error", 64'(de[1]), 64'd0);
        chk("wait_rst_rdata", drd[1],     64'd0);
        chk("wait_rst_busy",  64'(bz[1]), 64'd0);
        rst     = 1'b0;
        wr_r[1] = 1'b0;
        repeat (4) @(posedge clk);
        issue(1, 1, 0, BASE, 3'd3, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 0, 0);

        // LATENCY 1: request held across a 16-word sweep
        for (int i = 0; i < 16; i++) begin
            issue(2, 1, 0, BASE + 64'(8 * (i + 2)), 3'd3, 8'h00, 64'd0, pre(i + 2), 0,
                  (i != 15));
        end

        // LATENCY 1: back-door write colliding with the committing store
        @(posedge clk); #1;
        addr = BASE + 24; wr_len = 3'd3; wr_mask = 8'h0F; data_Wr = 64'h0000_0000_1234_5678;
        wr_r[2] = 1'b1;
        e0.inst = 2; e0.cyc = cyc + 1; e0.data = 64'd0; e0.err = 1'b0;
        sbq.push_back(e0);
        @(posedge clk); #1;
        init_wen  = 1'b1;
        init_idx  = 12'd3;
        init_data = 64'h5555_5555_5555_5555;
        wr_r[2]   = 1'b0;
        @(posedge clk); #1;
        init_wen = 1'b0;
        issue(2, 1, 0, BASE + 24, 3'd3, 8'h00, 64'd0, 64'h5555_5555_1234_5678, 0, 0);

        repeat (5) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
